// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: host-side FIFO and launcher for a UART transmitter FSM.
// Buffers host words in a circular FIFO, hands one word at a time to the
// transmitter with a single-cycle start pulse, and paces launches on CTS and
// Tx_Busy. A transmitter that never raises Tx_Busy after a start pulse sets a
// sticky Ack_Timeout flag.
// Optional build macro: UART_TX_FEEDER_FLUSH_EN adds a synchronous Flush input
// that empties the FIFO without disturbing a word already being launched.
module uart_tx_feeder #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            Wr_En,
  input  logic [DATA_BITS-1:0]            Wr_Data,
  input  logic                            CTS,
  input  logic                            Tx_Busy,
`ifdef UART_TX_FEEDER_FLUSH_EN
  input  logic                            Flush,
`endif
  output logic [DATA_BITS-1:0]            Tx_Data_Out,
  output logic                            Transmit_Start_Out,
  output logic                            FIFO_Empty,
  output logic                            FIFO_Full,
  output logic [$clog2(FIFO_DEPTH):0]     Level,
  output logic                            Wr_Overflow,
  output logic                            Ack_Timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 ack_to_q, ack_to_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic flush;
  logic push;
  logic pop;

`ifdef UART_TX_FEEDER_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Fullness is judged on the registered flag, so a write to a full FIFO is
  // rejected even when a pop happens on the same edge. Flush overrides both.
  assign push = Wr_En && !full_q && !flush;
  assign pop  = (state_q == IDLE) && (count_q != '0) && CTS && !Tx_Busy && !flush;

  // Next-state, FIFO bookkeeping and status flag computation
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    ack_to_d  = ack_to_q;
    tmo_cnt_d = tmo_cnt_q;
    ovf_d     = Wr_En && full_q && !flush;

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (Tx_Busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          // The word is abandoned; the FIFO moves on to the next one.
          ack_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!Tx_Busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
  end

  // State and control registers; Rst clears everything immediately
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ack_to_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      ack_to_q  <= ack_to_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // FIFO storage write port; contents need no reset since count gates reads
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= Wr_Data;
    end
  end

  // Start is decoded from the state flop so it falls as soon as Rst rises.
  assign Transmit_Start_Out = (state_q == LAUNCH);
  assign Tx_Data_Out        = tx_data_q;
  assign FIFO_Empty         = empty_q;
  assign FIFO_Full          = full_q;
  assign Level              = count_q;
  assign Wr_Overflow        = ovf_q;
  assign Ack_Timeout        = ack_to_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed testbench for uart_tx_feeder with a simple transmitter model.
module tb_uart_tx_feeder;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Wr_En = 1'b0;
  logic [7:0] Wr_Data = 8'h00;
  logic       CTS = 1'b0;
  logic       Tx_Busy = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic       Flush = 1'b0;
`endif
  logic [7:0] Tx_Data_Out;
  logic       Transmit_Start_Out;
  logic       FIFO_Empty;
  logic       FIFO_Full;
  logic [3:0] Level;
  logic       Wr_Overflow;
  logic       Ack_Timeout;

  uart_tx_feeder #(.DATA_BITS(8), .FIFO_DEPTH(8), .ACK_TIMEOUT(4)) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .Wr_En              (Wr_En),
    .Wr_Data            (Wr_Data),
    .CTS                (CTS),
    .Tx_Busy            (Tx_Busy),
`ifdef UART_TX_FEEDER_FLUSH_EN
    .Flush              (Flush),
`endif
    .Tx_Data_Out        (Tx_Data_Out),
    .Transmit_Start_Out (Transmit_Start_Out),
    .FIFO_Empty         (FIFO_Empty),
    .FIFO_Full          (FIFO_Full),
    .Level              (Level),
    .Wr_Overflow        (Wr_Overflow),
    .Ack_Timeout        (Ack_Timeout)
  );

  always #5 Clk = ~Clk;

  // Transmitter model: Tx_Busy rises one cycle after a start pulse, 10 cycles long.
  logic model_en = 1'b1;
  int   busy_cnt = 0;
  always @(negedge Clk) begin
    if (Transmit_Start_Out === 1'b1 && model_en) busy_cnt = 11;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    Tx_Busy = (busy_cnt > 0) && (busy_cnt <= 10);
  end

  // Log of every launched word, sampled mid-cycle.
  logic [7:0] lq[$];
  always @(negedge Clk) begin
    if (Transmit_Start_Out === 1'b1) lq.push_back(Tx_Data_Out);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    Wr_En = 1'b1; Wr_Data = d;
    tick();
    Wr_En = 1'b0;
  endtask

  task automatic wait_launches(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (lq.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, lq.size(), target);
  endtask

  task automatic wait_busy(input int budget);
    int k;
    k = 0;
    while (!Tx_Busy && k < budget) begin
      tick();
      k++;
    end
    chk("busy_seen", Tx_Busy, 1);
  endtask

  function automatic logic [7:0] lq_at(input int idx);
    logic [7:0] v;
    v = 8'hxx;
    if (idx < lq.size()) v = lq[idx];
    return v;
  endfunction

  initial begin
    int base;
    // ---- reset state ----
    tick(2);
    chk("rst_empty", FIFO_Empty, 1);
    chk("rst_full", FIFO_Full, 0);
    chk("rst_level", Level, 0);
    chk("rst_start", Transmit_Start_Out, 0);
    chk("rst_data", Tx_Data_Out, 0);
    chk("rst_ovf", Wr_Overflow, 0);
    chk("rst_ackto", Ack_Timeout, 0);
    Rst = 1'b0;
    tick();

    // ---- single write, 2-cycle latency ----
    CTS = 1'b1;
    wr(8'hA5);
    chk("t1_start_early", Transmit_Start_Out, 0);
    chk("t1_level1", Level, 1);
    tick();
    chk("t1_start", Transmit_Start_Out, 1);
    chk("t1_data", Tx_Data_Out, 8'hA5);
    chk("t1_empty", FIFO_Empty, 1);
    tick(20);
    chk("t1_one_pulse", lq.size(), 1);
    chk("t1_hold_data", Tx_Data_Out, 8'hA5);
    chk("t1_no_ackto", Ack_Timeout, 0);

    // ---- burst of 9 with CTS low, overflow, ordered drain across wrap ----
    CTS = 1'b0;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk("t2_full", FIFO_Full, 1);
    chk("t2_level8", Level, 8);
    chk("t2_no_ovf_yet", Wr_Overflow, 0);
    wr(8'h09);
    chk("t2_ovf", Wr_Overflow, 1);
    chk("t2_level_kept", Level, 8);
    tick();
    chk("t2_ovf_pulse", Wr_Overflow, 0);
    base = lq.size();
    CTS = 1'b1;
    wait_launches("t2_launches", base + 8, 250);
    for (int k = 0; k < 8; k++) chk($sformatf("t2_order%0d", k), lq_at(base + k), 8'(k + 1));
    tick(20);
    chk("t2_drained", FIFO_Empty, 1);
    chk("t2_no_extra", lq.size(), base + 8);

    // ---- full FIFO write on the same edge as a pop; then ack timeout ----
    CTS = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    chk("t3_full", FIFO_Full, 1);
    model_en = 1'b0;
    CTS = 1'b1;
    wr(8'h55);
    chk("t3_ovf", Wr_Overflow, 1);
    chk("t3_level7", Level, 7);
    chk("t3_notfull", FIFO_Full, 0);
    chk("t3_start", Transmit_Start_Out, 1);
    chk("t3_head", Tx_Data_Out, 8'h10);
    tick(4);
    chk("t4_ackto_early", Ack_Timeout, 0);
    tick();
    chk("t4_ackto_set", Ack_Timeout, 1);
    tick();
    chk("t4_next_start", Transmit_Start_Out, 1);
    chk("t4_next_data", Tx_Data_Out, 8'h11);
    CTS = 1'b0;
    tick(12);
    chk("t4_sticky", Ack_Timeout, 1);

    // ---- reset during WAIT_DONE with words queued ----
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    model_en = 1'b1;
    chk("t5_ackto_cleared", Ack_Timeout, 0);
    for (int i = 0; i < 4; i++) wr(8'h21 + 8'(i));
    CTS = 1'b1;
    wait_busy(40);
    tick(2);
    chk("t5_level3", Level, 3);
    #2 Rst = 1'b1;
    #1;
    chk("t5_async_level", Level, 0);
    chk("t5_async_empty", FIFO_Empty, 1);
    chk("t5_async_data", Tx_Data_Out, 0);
    chk("t5_async_start", Transmit_Start_Out, 0);
    tick();
    Rst = 1'b0;
    base = lq.size();
    tick(30);
    chk("t5_no_launch", lq.size(), base);
    wr(8'h66);
    wait_launches("t5_relaunch", base + 1, 40);
    chk("t5_relaunch_start", Transmit_Start_Out, 1);
    #1 Rst = 1'b1;
    #1;
    chk("t5_start_async_drop", Transmit_Start_Out, 0);
    tick();
    Rst = 1'b0;
    tick(15);

`ifdef UART_TX_FEEDER_FLUSH_EN
    // ---- flush together with a write during WAIT_DONE ----
    CTS = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h31 + 8'(i));
    CTS = 1'b1;
    base = lq.size();
    wait_busy(40);
    tick(2);
    chk("f_level4", Level, 4);
    Flush = 1'b1; Wr_En = 1'b1; Wr_Data = 8'h99;
    tick();
    Flush = 1'b0; Wr_En = 1'b0;
    chk("f_level0", Level, 0);
    chk("f_empty", FIFO_Empty, 1);
    chk("f_no_ovf", Wr_Overflow, 0);
    tick(40);
    chk("f_one_launch", lq.size(), base + 1);
    chk("f_word_done", Tx_Busy, 0);
    chk("f_no_ackto", Ack_Timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
